// File: rtl/ad_frame_aligner_pkg.sv
// Shared constants, state encoding and small helpers for the ADC frame aligner.
package ad_frame_aligner_pkg;

    localparam int AD_DATA_NBIT = 18;
    localparam int FRAME_LEN    = 512;
    localparam int SYNC_LEN     = 9;
    localparam int ERR_NBIT     = 8;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_ARM  = 2'd1,
        ST_SYNC = 2'd2,
        ST_ACQ  = 2'd3
    } af_state_t;

    function automatic logic [ERR_NBIT-1:0] sat_inc(input logic [ERR_NBIT-1:0] value);
        return (value == {ERR_NBIT{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/ad_frame_aligner_sig_sync_edge.sv
// N-flop synchroniser for an asynchronous input, with a one-cycle rising-edge strobe.
module ad_frame_aligner_sig_sync_edge #(
    parameter int NFLOP = 2
) (
    input  logic mclk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise
);

    logic [NFLOP-1:0] chain;
    logic             level_dly;

    // The extra delay flop sits after the synchroniser so the edge strobe only sees settled values.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            chain     <= '0;
            level_dly <= 1'b0;
        end else begin
            chain     <= {chain[NFLOP-2:0], din};
            level_dly <= chain[NFLOP-1];
        end
    end

    assign level = chain[NFLOP-1];
    assign rise  = chain[NFLOP-1] & ~level_dly;

endmodule

// File: rtl/ad_frame_aligner.sv
// Aligns AD7960 conversions to the external sample clock and frame sync, tagging each
// emitted sample with line position, line count and staleness, and tracking framing errors.
module ad_frame_aligner
    import ad_frame_aligner_pkg::*;
#(
    parameter int DATA_NBIT = AD_DATA_NBIT,
    parameter int IDX_NBIT  = 9,
    parameter int FRAME_LEN = ad_frame_aligner_pkg::FRAME_LEN,
    parameter int SYNC_LEN  = ad_frame_aligner_pkg::SYNC_LEN,
    parameter int LINE_NBIT = 8
) (
    input  logic                 mclk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic                 sync,
    input  logic                 spclk,
    input  logic                 ad_vld,
    input  logic [DATA_NBIT-1:0] ad_data,
    output logic                 out_vd,
    output logic [DATA_NBIT-1:0] out_data,
    output logic [IDX_NBIT-1:0]  out_idx,
    output logic                 out_sop,
    output logic                 out_eop,
    output logic                 out_stale,
    output logic [LINE_NBIT-1:0] out_line,
    output logic                 locked,
    output logic [ERR_NBIT-1:0]  err_cnt
);

    localparam logic [IDX_NBIT-1:0] IDX_SYNC_END = IDX_NBIT'(SYNC_LEN);
    localparam logic [IDX_NBIT-1:0] IDX_LAST     = IDX_NBIT'(FRAME_LEN - 1);

    logic                 spclk_rise;
    logic                 spclk_lvl_unused;
    logic                 sync_lvl;
    logic                 sync_rise_unused;

    af_state_t            state;
    logic [IDX_NBIT-1:0]  idx;
    logic [DATA_NBIT-1:0] hold;
    logic                 stale_flag;
    logic [DATA_NBIT-1:0] emit_data;
    logic                 emit_stale;

    ad_frame_aligner_sig_sync_edge #(.NFLOP(2)) u_spclk_sync (
        .mclk    (mclk),
        .reset_n (reset_n),
        .din     (spclk),
        .level   (spclk_lvl_unused),
        .rise    (spclk_rise)
    );

    ad_frame_aligner_sig_sync_edge #(.NFLOP(2)) u_sync_sync (
        .mclk    (mclk),
        .reset_n (reset_n),
        .din     (sync),
        .level   (sync_lvl),
        .rise    (sync_rise_unused)
    );

    // A conversion landing in the same cycle as the sample edge is fresher than the hold register.
    assign emit_data  = ad_vld ? ad_data : hold;
    assign emit_stale = stale_flag & ~ad_vld;
    assign locked     = (state == ST_SYNC) || (state == ST_ACQ);

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_HUNT;
            idx        <= '0;
            hold       <= '0;
            stale_flag <= 1'b1;
            out_vd     <= 1'b0;
            out_data   <= '0;
            out_idx    <= '0;
            out_sop    <= 1'b0;
            out_eop    <= 1'b0;
            out_stale  <= 1'b0;
            out_line   <= '0;
            err_cnt    <= '0;
        end else begin
            out_vd    <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_stale <= 1'b0;

            if (ad_vld) begin
                hold       <= ad_data;
                stale_flag <= 1'b0;
            end

            if (!en) begin
                state    <= ST_HUNT;
                idx      <= '0;
                out_line <= '0;
                err_cnt  <= '0;
            end else if (spclk_rise) begin
                unique case (state)
                    // Only leave HUNT once sync is seen low, so the next high is a true leading edge.
                    ST_HUNT: begin
                        if (!sync_lvl) begin
                            state <= ST_ARM;
                        end
                    end

                    ST_ARM: begin
                        if (sync_lvl) begin
                            out_vd     <= 1'b1;
                            out_data   <= emit_data;
                            out_stale  <= emit_stale;
                            out_idx    <= '0;
                            out_sop    <= 1'b1;
                            stale_flag <= 1'b1;
                            idx        <= IDX_NBIT'(1);
                            state      <= ST_SYNC;
                        end
                    end

                    ST_SYNC: begin
                        if (sync_lvl) begin
                            if (idx < IDX_SYNC_END) begin
                                out_vd     <= 1'b1;
                                out_data   <= emit_data;
                                out_stale  <= emit_stale;
                                out_idx    <= idx;
                                stale_flag <= 1'b1;
                                idx        <= idx + 1'b1;
                            end else begin
                                err_cnt <= sat_inc(err_cnt);
                                idx     <= '0;
                                state   <= ST_HUNT;
                            end
                        end else begin
                            if (idx >= IDX_SYNC_END) begin
                                out_vd     <= 1'b1;
                                out_data   <= emit_data;
                                out_stale  <= emit_stale;
                                out_idx    <= idx;
                                stale_flag <= 1'b1;
                                idx        <= idx + 1'b1;
                                state      <= ST_ACQ;
                            end else begin
                                err_cnt <= sat_inc(err_cnt);
                                idx     <= '0;
                                state   <= ST_ARM;
                            end
                        end
                    end

                    // A sync edge mid-line restarts the line; the truncated one never gets an eop.
                    ST_ACQ: begin
                        out_vd     <= 1'b1;
                        out_data   <= emit_data;
                        out_stale  <= emit_stale;
                        stale_flag <= 1'b1;
                        if (sync_lvl) begin
                            err_cnt <= sat_inc(err_cnt);
                            out_idx <= '0;
                            out_sop <= 1'b1;
                            idx     <= IDX_NBIT'(1);
                            state   <= ST_SYNC;
                        end else if (idx >= IDX_LAST) begin
                            out_idx  <= IDX_LAST;
                            out_eop  <= 1'b1;
                            out_line <= out_line + 1'b1;
                            idx      <= '0;
                            state    <= ST_ARM;
                        end else begin
                            out_idx <= idx;
                            idx     <= idx + 1'b1;
                        end
                    end

                    default: begin
                        idx   <= '0;
                        state <= ST_HUNT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ad_frame_aligner.sv
// Directed bench for ad_frame_aligner: one sample-clock period per applyStimulus call (6 mclk).
module tb_ad_frame_aligner;

    logic        mclk = 1'b0;
    logic        reset_n;
    logic        en;
    logic        sync;
    logic        spclk;
    logic        ad_vld;
    logic [17:0] ad_data;
    logic        out_vd;
    logic [17:0] out_data;
    logic [8:0]  out_idx;
    logic        out_sop;
    logic        out_eop;
    logic        out_stale;
    logic [7:0]  out_line;
    logic        locked;
    logic [7:0]  err_cnt;

    int          checks = 0;
    int          failures = 0;
    logic [17:0] ramp = 18'h00100;

    logic        s_vd, s_sop, s_eop, s_stale, s_locked;
    logic [8:0]  s_idx;
    logic [17:0] s_data;
    logic [7:0]  s_line, s_err;

    ad_frame_aligner dut (
        .mclk      (mclk),
        .reset_n   (reset_n),
        .en        (en),
        .sync      (sync),
        .spclk     (spclk),
        .ad_vld    (ad_vld),
        .ad_data   (ad_data),
        .out_vd    (out_vd),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_stale (out_stale),
        .out_line  (out_line),
        .locked    (locked),
        .err_cnt   (err_cnt)
    );

    always #5 mclk = ~mclk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // vld_mode: 0 = no conversion, 1 = conversion well before the edge, 2 = conversion on the edge cycle.
    task automatic applyStimulus(input logic sync_val, input int vld_mode, input logic [17:0] data_val);
        @(negedge mclk);
        sync = sync_val;
        if (vld_mode == 1) begin
            ad_vld  = 1'b1;
            ad_data = data_val;
        end
        @(negedge mclk);
        ad_vld = 1'b0;
        spclk  = 1'b1;
        @(negedge mclk);
        @(negedge mclk);
        if (vld_mode == 2) begin
            ad_vld  = 1'b1;
            ad_data = data_val;
        end
        @(negedge mclk);
        ad_vld   = 1'b0;
        spclk    = 1'b0;
        s_vd     = out_vd;
        s_data   = out_data;
        s_idx    = out_idx;
        s_sop    = out_sop;
        s_eop    = out_eop;
        s_stale  = out_stale;
        s_line   = out_line;
        s_err    = err_cnt;
        s_locked = locked;
        @(negedge mclk);
    endtask

    task automatic expectEmit(input string tag, input int idx, input logic sop, input logic eop,
                              input logic stale, input logic [17:0] data);
        checkOutput({tag, ".vd"}, 32'(s_vd), 32'd1);
        checkOutput({tag, ".idx"}, 32'(s_idx), 32'(idx));
        checkOutput({tag, ".sop"}, 32'(s_sop), 32'(sop));
        checkOutput({tag, ".eop"}, 32'(s_eop), 32'(eop));
        checkOutput({tag, ".stale"}, 32'(s_stale), 32'(stale));
        checkOutput({tag, ".data"}, 32'(s_data), 32'(data));
    endtask

    task automatic expectIdle(input string tag);
        checkOutput({tag, ".vd"}, 32'(s_vd), 32'd0);
        checkOutput({tag, ".idx"}, 32'(s_idx), 32'd0);
        checkOutput({tag, ".data"}, 32'(s_data), 32'd0);
    endtask

    task automatic emitPeriod(input logic sync_val, input string tag, input int idx,
                              input logic sop, input logic eop);
        ramp = ramp + 18'd3;
        applyStimulus(sync_val, 1, ramp);
        expectEmit(tag, idx, sop, eop, 1'b0, ramp);
    endtask

    task automatic idlePeriod(input logic sync_val, input string tag);
        ramp = ramp + 18'd3;
        applyStimulus(sync_val, 1, ramp);
        expectIdle(tag);
    endtask

    initial begin
        reset_n = 1'b0;
        en      = 1'b0;
        sync    = 1'b0;
        spclk   = 1'b0;
        ad_vld  = 1'b0;
        ad_data = '0;
        repeat (3) @(negedge mclk);
        checkOutput("rst.vd", 32'(out_vd), 32'd0);
        checkOutput("rst.data", 32'(out_data), 32'd0);
        checkOutput("rst.idx", 32'(out_idx), 32'd0);
        checkOutput("rst.sop", 32'(out_sop), 32'd0);
        checkOutput("rst.eop", 32'(out_eop), 32'd0);
        checkOutput("rst.line", 32'(out_line), 32'd0);
        checkOutput("rst.locked", 32'(locked), 32'd0);
        checkOutput("rst.err", 32'(err_cnt), 32'd0);
        reset_n = 1'b1;
        @(negedge mclk);
        en = 1'b1;

        // Ideal first line
        for (int i = 0; i < 3; i++) idlePeriod(1'b0, $sformatf("pre[%0d]", i));
        for (int i = 0; i < 512; i++) begin
            emitPeriod(i < 9, $sformatf("l1[%0d]", i), i, i == 0, i == 511);
            if (i == 0) checkOutput("l1.locked", 32'(s_locked), 32'd1);
            if (i == 510) checkOutput("l1.line_before", 32'(s_line), 32'd0);
        end
        checkOutput("l1.line_after", 32'(s_line), 32'd1);
        checkOutput("l1.err", 32'(s_err), 32'd0);
        checkOutput("l1.unlocked", 32'(s_locked), 32'd0);

        // Second line: bypass, stale, then an early sync at index 300
        for (int i = 0; i < 300; i++) begin
            if (i == 20) begin
                applyStimulus(1'b0, 2, 18'h2AAAA);
                expectEmit("byp", 20, 1'b0, 1'b0, 1'b0, 18'h2AAAA);
            end else if (i == 21) begin
                applyStimulus(1'b0, 0, 18'h3FFFF);
                expectEmit("stale", 21, 1'b0, 1'b0, 1'b1, 18'h2AAAA);
            end else begin
                emitPeriod(i < 9, $sformatf("l2[%0d]", i), i, i == 0, 1'b0);
            end
        end
        emitPeriod(1'b1, "early", 0, 1'b1, 1'b0);
        checkOutput("early.err", 32'(s_err), 32'd1);
        checkOutput("early.line", 32'(s_line), 32'd1);

        // The restarted pulse is only 5 periods long
        for (int j = 1; j < 5; j++) emitPeriod(1'b1, $sformatf("short[%0d]", j), j, 1'b0, 1'b0);
        idlePeriod(1'b0, "short.end");
        checkOutput("short.err", 32'(s_err), 32'd2);
        checkOutput("short.unlocked", 32'(s_locked), 32'd0);
        for (int j = 0; j < 20; j++) idlePeriod(1'b0, $sformatf("short.gap[%0d]", j));

        // Good pulse relocks; line runs to index 199 before en drops
        for (int i = 0; i < 200; i++) begin
            emitPeriod(i < 9, $sformatf("l3[%0d]", i), i, i == 0, 1'b0);
            if (i == 0) checkOutput("l3.locked", 32'(s_locked), 32'd1);
        end
        en = 1'b0;
        idlePeriod(1'b0, "dis[200]");
        checkOutput("dis.line", 32'(s_line), 32'd0);
        checkOutput("dis.err", 32'(s_err), 32'd0);
        checkOutput("dis.unlocked", 32'(s_locked), 32'd0);
        for (int i = 201; i < 512; i++) begin
            applyStimulus(1'b0, 1, ramp);
            checkOutput("dis.vd", 32'(s_vd), 32'd0);
        end
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < 512; i++) begin
                applyStimulus(i < 9, 1, ramp);
                checkOutput("dis.vd", 32'(s_vd), 32'd0);
            end
        end
        for (int i = 0; i < 4; i++) idlePeriod(1'b1, $sformatf("dis.l6[%0d]", i));

        // en returns mid-pulse: nothing until the next full pulse
        en = 1'b1;
        for (int i = 4; i < 512; i++) begin
            idlePeriod(i < 9, $sformatf("mid[%0d]", i));
            if (i == 4 || i == 100) checkOutput("mid.unlocked", 32'(s_locked), 32'd0);
        end
        for (int i = 0; i < 512; i++) begin
            emitPeriod(i < 9, $sformatf("l7[%0d]", i), i, i == 0, i == 511);
            if (i == 0) checkOutput("l7.line_start", 32'(s_line), 32'd0);
        end
        checkOutput("l7.line", 32'(s_line), 32'd1);
        checkOutput("l7.err", 32'(s_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ad_frame_aligner.md
Name: ad_frame_aligner

Overview:
- Sits between the AD7960 controller and ad_cache, in the mclk (100 MHz) domain.
- Synchronises the external frame sync and 200 kHz sample clock and, on every sample-clock rising edge, emits the most recent ADC conversion.
- Tags each emitted sample with its index in the line, start/end-of-line markers, a line counter and a stale flag.
- Checks sync-pulse length and line length, flags violations and re-locks.

Parameters:
DATA_NBIT, 18, ADC sample width
IDX_NBIT, 9, sample-index width
FRAME_LEN, 512, samples per line (index 0..FRAME_LEN-1)
SYNC_LEN, 9, sample-clock periods with sync high at line start (indices 0..SYNC_LEN-1)
LINE_NBIT, 8, line counter width

Ports:
mclk  in  1  system clock, 100 MHz
reset_n  in  1  asynchronous active-low reset
en  in  1  acquisition enable (from cmd_decode ad_acq_en)
sync  in  1  external frame sync, asynchronous
spclk  in  1  external sample clock, asynchronous
ad_vld  in  1  one-cycle pulse, new conversion on ad_data (mclk-synchronous)
ad_data  in  DATA_NBIT  conversion result
out_vd  out  1  one-cycle sample strobe
out_data  out  DATA_NBIT  sample value
out_idx  out  IDX_NBIT  index within line
out_sop  out  1  with out_vd, index 0
out_eop  out  1  with out_vd, index FRAME_LEN-1
out_stale  out  1  with out_vd, no ad_vld since previous emission
out_line  out  LINE_NBIT  completed-line count
locked  out  1  state is SYNC or ACQ
err_cnt  out  8  saturating count of framing errors

Behaviour:
- Reset: all outputs 0, state HUNT, hold register 0, stale flag set.
- Synchronisers: sync and spclk each pass through 2 flops.
  - A third spclk flop gives spclk_rise = (s[2:1]==2'b01).
  - The sync level used is the synchronised value in the spclk_rise cycle.
- Hold register: loads ad_data on ad_vld.
  - Emission uses ad_data directly if ad_vld coincides with spclk_rise (bypass); otherwise it uses the hold register.
  - stale_flag clears on ad_vld and sets on each emission; out_stale is the value before that emission's set.
- Latency: out_* are registered, so out_vd rises 1 mclk after the spclk_rise cycle. This is 4 mclk worst case from the spclk pin edge.
- out_sop, out_eop, out_idx, out_data and out_stale are valid only while out_vd=1. They are 0 otherwise.
- State machine (transitions evaluated only on spclk_rise unless noted):
  - HUNT: sync low -> ARM. Sync high -> stay, no emission. This guarantees a sync leading edge is observed.
  - ARM: sync high -> emit idx 0 with sop; idx<=1; go SYNC. Sync low -> stay, no emission.
  - SYNC, sync high and idx<SYNC_LEN: emit idx, idx++.
  - SYNC, sync high and idx==SYNC_LEN: pulse too long. err_cnt++, no emission, -> HUNT.
  - SYNC, sync low and idx==SYNC_LEN: emit idx, idx++, -> ACQ.
  - SYNC, sync low and idx<SYNC_LEN: pulse too short. err_cnt++, no emission, -> ARM.
  - ACQ, sync low and idx<FRAME_LEN-1: emit idx, idx++.
  - ACQ, sync low and idx==FRAME_LEN-1: emit with eop; out_line++ (wraps); -> ARM.
  - ACQ, sync high: early line start. err_cnt++; emit idx 0 with sop; idx<=1; -> SYNC. The truncated line gets no eop.
- en low (checked every cycle, overrides everything):
  - state -> HUNT, idx, out_line and err_cnt cleared, no emission.
  - A line in flight is dropped with no eop.
  - en rising starts in HUNT.
- err_cnt saturates at 255.
- The index counter never exceeds FRAME_LEN-1.
- ad_vld arriving with no spclk_rise only updates the hold register.
- A missing spclk stalls the state machine indefinitely; there is no timeout.
- Two spclk_rise events closer than 3 mclk are out of spec; behaviour is undefined but must not hang.

Decomposition:
- The shared globals package holds AD_DATA_NBIT, FRAME_LEN, SYNC_LEN and the state encoding constants (HUNT/ARM/SYNC/ACQ).
- One natural sub-module is sig_sync_edge: an N-flop synchroniser with rising-edge output, instanced for spclk (edge used) and sync (level used).

Test Plan:
- Ideal stimulus: reset, en=1, spclk 200 kHz, sync high for 9 periods every 512 periods, ad_vld one per spclk with a ramp. Required: first emitted line has idx 0..511, sop only at idx 0, eop only at idx 511, out_line 0->1, err_cnt 0, locked=1 after the first sop.
- Start mid-pulse: release en while sync is high (mid-pulse). Required: no emission until the next full sync pulse; first out_vd has sop=1, idx=0.
- Short pulse: sync high for only 5 periods. Required: err_cnt=1, state ARM, no out_vd after idx 4 until the next pulse; the next good pulse gives sop at idx 0.
- Early sync: sync high at line index 300. Required: err_cnt++, that edge emits idx 0 with sop, no eop for the truncated line, out_line unchanged.
- Bypass and stale: ad_vld in the same cycle as spclk_rise with ad_data=0x2AAAA gives out_data=0x2AAAA one cycle later. Omitting ad_vld for one period gives out_stale=1 and out_data equal to the previous value.
- Mid-line disable: drop en at idx 200, then raise it 3 lines later. Required: out_vd stops immediately, out_line=0 and err_cnt=0, relock on the next full sync pulse.
